// File: rtl/mastermind_turn_controller.sv
// Mastermind turn and role sequencer: runs MAX_ROUNDS rounds, rotates the
// code-maker / code-breaker roles, counts guesses against GUESS_LIMIT and
// produces the maker's point value for each round.
module mastermind_turn_controller #(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_ROUNDS  = 4,
    parameter int GUESS_LIMIT = 8,
    parameter int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    parameter int GW = $clog2(GUESS_LIMIT + 2),
    parameter int RW = (MAX_ROUNDS > 2) ? $clog2(MAX_ROUNDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   code_valid,
    input  logic                   guess_valid,
    input  logic                   guess_correct,
    output logic [NUM_PLAYERS-1:0] active_player,
    output logic [PW-1:0]          maker_id,
    output logic [PW-1:0]          breaker_id,
    output logic                   code_maker,
    output logic                   code_breaker,
    output logic [GW-1:0]          guess_count,
    output logic [RW-1:0]          round,
    output logic                   round_done,
    output logic [GW-1:0]          round_points,
    output logic                   game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAKE,
        S_BREAK,
        S_SCORE,
        S_DONE
    } state_t;

    state_t          state;
    logic [RW-1:0]   round_q;
    logic [GW-1:0]   count_q;
    logic [GW-1:0]   points_q;
    logic [GW-1:0]   count_next;
    logic [PW-1:0]   maker_idx;
    logic [PW-1:0]   breaker_idx;
    logic [NUM_PLAYERS-1:0] one_hot_base;

    assign count_next   = count_q + GW'(1);
    assign maker_idx    = PW'(int'(round_q) % NUM_PLAYERS);
    assign breaker_idx  = PW'((int'(maker_idx) + 1) % NUM_PLAYERS);
    assign one_hot_base = {{(NUM_PLAYERS-1){1'b0}}, 1'b1};

    // Round/turn state machine; the guess that ends a round also latches its points
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            round_q  <= '0;
            count_q  <= '0;
            points_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_MAKE;
                        round_q <= '0;
                        count_q <= '0;
                    end
                end
                S_MAKE: begin
                    if (code_valid) begin
                        state   <= S_BREAK;
                        count_q <= '0;
                    end
                end
                S_BREAK: begin
                    if (guess_valid) begin
                        count_q <= count_next;
                        if (guess_correct) begin
                            points_q <= count_next;
                            state    <= S_SCORE;
                        end else if (count_next == GW'(GUESS_LIMIT)) begin
                            // Unsolved round: maker earns one more than the limit
                            points_q <= GW'(GUESS_LIMIT + 1);
                            state    <= S_SCORE;
                        end
                    end
                end
                S_SCORE: begin
                    if (round_q == RW'(MAX_ROUNDS - 1)) begin
                        state <= S_DONE;
                    end else begin
                        round_q <= round_q + RW'(1);
                        count_q <= '0;
                        state   <= S_MAKE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state    <= S_MAKE;
                        round_q  <= '0;
                        count_q  <= '0;
                        points_q <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore output decode from registered state and counters
    always_comb begin
        active_player = '0;
        if (state == S_MAKE)
            active_player = one_hot_base << maker_idx;
        else if (state == S_BREAK)
            active_player = one_hot_base << breaker_idx;
    end

    // Role indices read as zero while idle so reset leaves every output at 0
    assign maker_id     = (state == S_IDLE) ? '0 : maker_idx;
    assign breaker_id   = (state == S_IDLE) ? '0 : breaker_idx;
    assign code_maker   = (state == S_MAKE);
    assign code_breaker = (state == S_BREAK);
    assign guess_count  = count_q;
    assign round        = round_q;
    assign round_done   = (state == S_SCORE);
    assign round_points = points_q;
    assign game_over    = (state == S_DONE);

endmodule

// File: tb/tb_mastermind_turn_controller.sv
// Directed bench for mastermind_turn_controller: a 2-player game covering
// roles, scoring, limit handling, ignored inputs and restart, plus a
// 3-player instance for role rotation and mid-round reset.
module tb_mastermind_turn_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two-player instance
    logic       reset, start, code_valid, guess_valid, guess_correct;
    logic [1:0] active_player;
    logic [0:0] maker_id, breaker_id;
    logic       code_maker, code_breaker, round_done, game_over;
    logic [3:0] guess_count, round_points;
    logic [1:0] round;

    mastermind_turn_controller #(.NUM_PLAYERS(2), .MAX_ROUNDS(4), .GUESS_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .code_valid(code_valid),
        .guess_valid(guess_valid), .guess_correct(guess_correct),
        .active_player(active_player), .maker_id(maker_id), .breaker_id(breaker_id),
        .code_maker(code_maker), .code_breaker(code_breaker), .guess_count(guess_count),
        .round(round), .round_done(round_done), .round_points(round_points),
        .game_over(game_over)
    );

    // Three-player instance
    logic       reset3, start3, code_valid3, guess_valid3, guess_correct3;
    logic [2:0] active_player3;
    logic [1:0] maker_id3, breaker_id3;
    logic       code_maker3, code_breaker3, round_done3, game_over3;
    logic [3:0] guess_count3, round_points3;
    logic [1:0] round3;

    mastermind_turn_controller #(.NUM_PLAYERS(3), .MAX_ROUNDS(4), .GUESS_LIMIT(8)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .code_valid(code_valid3),
        .guess_valid(guess_valid3), .guess_correct(guess_correct3),
        .active_player(active_player3), .maker_id(maker_id3), .breaker_id(breaker_id3),
        .code_maker(code_maker3), .code_breaker(code_breaker3), .guess_count(guess_count3),
        .round(round3), .round_done(round_done3), .round_points(round_points3),
        .game_over(game_over3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted guess on the two-player instance
    task automatic guess(input logic correct);
        guess_valid   = 1'b1;
        guess_correct = correct;
        tick();
        guess_valid   = 1'b0;
        guess_correct = 1'b0;
    endtask

    task automatic check_all_zero2(input string tag);
        chk({tag, ".active"},  active_player, 0);
        chk({tag, ".maker"},   maker_id, 0);
        chk({tag, ".breaker"}, breaker_id, 0);
        chk({tag, ".cm"},      code_maker, 0);
        chk({tag, ".cb"},      code_breaker, 0);
        chk({tag, ".gc"},      guess_count, 0);
        chk({tag, ".round"},   round, 0);
        chk({tag, ".rdone"},   round_done, 0);
        chk({tag, ".pts"},     round_points, 0);
        chk({tag, ".over"},    game_over, 0);
    endtask

    int exp_mk [4] = '{0, 1, 2, 0};
    int exp_bk [4] = '{1, 2, 0, 1};

    initial begin
        reset = 1'b1; start = 1'b0; code_valid = 1'b0; guess_valid = 1'b0; guess_correct = 1'b0;
        reset3 = 1'b1; start3 = 1'b0; code_valid3 = 1'b0; guess_valid3 = 1'b0; guess_correct3 = 1'b0;
        #1;
        tick(); tick();
        reset = 1'b0; reset3 = 1'b0;
        tick();
        check_all_zero2("rst");

        // Start: round 0, A makes
        start = 1'b1; tick(); start = 1'b0;
        chk("make0.cm", code_maker, 1);
        chk("make0.maker", maker_id, 0);
        chk("make0.active", active_player, 2'b01);

        // Guess and start in MAKE are ignored
        guess_valid = 1'b1; guess_correct = 1'b1; start = 1'b1; tick();
        start = 1'b0;
        chk("make_ign.cm", code_maker, 1);
        chk("make_ign.gc", guess_count, 0);
        chk("make_ign.rdone", round_done, 0);

        // code_valid with guess_valid: BREAK, count still 0
        code_valid = 1'b1; tick();
        code_valid = 1'b0; guess_valid = 1'b0; guess_correct = 1'b0;
        chk("brk0.cb", code_breaker, 1);
        chk("brk0.breaker", breaker_id, 1);
        chk("brk0.active", active_player, 2'b10);
        chk("brk0.gc", guess_count, 0);

        // code_valid in BREAK ignored
        code_valid = 1'b1; tick(); code_valid = 1'b0;
        chk("brk_ign.cb", code_breaker, 1);
        chk("brk_ign.gc", guess_count, 0);

        // Three guesses, third correct
        guess(1'b0); guess(1'b0);
        chk("r0.gc2", guess_count, 2);
        guess(1'b1);
        chk("r0.rdone", round_done, 1);
        chk("r0.pts", round_points, 3);
        chk("r0.gc3", guess_count, 3);
        chk("r0.active", active_player, 0);
        tick();
        chk("r1.cm", code_maker, 1);
        chk("r1.round", round, 1);
        chk("r1.maker", maker_id, 1);
        chk("r1.active", active_player, 2'b10);
        chk("r1.rdone", round_done, 0);
        chk("r1.pts_held", round_points, 3);
        chk("r1.gc", guess_count, 0);

        // Round 1: eight wrong guesses reach the limit
        code_valid = 1'b1; tick(); code_valid = 1'b0;
        chk("r1.breaker", breaker_id, 0);
        chk("r1.bactive", active_player, 2'b01);
        for (int i = 0; i < 7; i++) guess(1'b0);
        chk("r1.gc7", guess_count, 7);
        chk("r1.cb7", code_breaker, 1);
        guess(1'b0);
        chk("r1.limit_rdone", round_done, 1);
        chk("r1.limit_pts", round_points, 9);
        chk("r1.limit_gc", guess_count, 8);
        // A ninth guess during SCORE is not accepted
        guess(1'b0);
        chk("r2.cm", code_maker, 1);
        chk("r2.round", round, 2);
        chk("r2.gc", guess_count, 0);
        chk("r2.maker", maker_id, 0);

        // Round 2: start mid-round ignored, first guess correct
        code_valid = 1'b1; tick(); code_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("r2.start_ign.cb", code_breaker, 1);
        chk("r2.start_ign.round", round, 2);
        guess(1'b1);
        chk("r2.pts", round_points, 1);
        chk("r2.rdone", round_done, 1);
        tick();
        chk("r3.round", round, 3);
        chk("r3.maker", maker_id, 1);

        // Round 3: solved exactly on the eighth guess
        code_valid = 1'b1; tick(); code_valid = 1'b0;
        for (int i = 0; i < 7; i++) guess(1'b0);
        guess(1'b1);
        chk("r3.pts", round_points, 8);
        chk("r3.rdone", round_done, 1);
        tick();
        chk("done.over", game_over, 1);
        chk("done.round", round, 3);
        chk("done.active", active_player, 0);
        chk("done.rdone", round_done, 0);
        code_valid = 1'b1; guess_valid = 1'b1; tick();
        code_valid = 1'b0; guess_valid = 1'b0;
        chk("done.hold", game_over, 1);
        chk("done.hold_round", round, 3);

        // Restart from DONE
        start = 1'b1; tick(); start = 1'b0;
        chk("restart.cm", code_maker, 1);
        chk("restart.round", round, 0);
        chk("restart.maker", maker_id, 0);
        chk("restart.over", game_over, 0);
        chk("restart.pts", round_points, 0);

        // Three players: role rotation over four rounds
        start3 = 1'b1; tick(); start3 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("p3.r%0d.maker", r), maker_id3, exp_mk[r]);
            chk($sformatf("p3.r%0d.mact", r), active_player3, 3'b001 << exp_mk[r]);
            code_valid3 = 1'b1; tick(); code_valid3 = 1'b0;
            chk($sformatf("p3.r%0d.breaker", r), breaker_id3, exp_bk[r]);
            chk($sformatf("p3.r%0d.bact", r), active_player3, 3'b001 << exp_bk[r]);
            guess_valid3 = 1'b1; guess_correct3 = 1'b1; tick();
            guess_valid3 = 1'b0; guess_correct3 = 1'b0;
            chk($sformatf("p3.r%0d.rdone", r), round_done3, 1);
            tick();
        end
        chk("p3.over", game_over3, 1);

        // Reset in the middle of BREAK
        start3 = 1'b1; tick(); start3 = 1'b0;
        code_valid3 = 1'b1; tick(); code_valid3 = 1'b0;
        guess_valid3 = 1'b1; tick(); guess_valid3 = 1'b0;
        chk("p3.pre_rst.gc", guess_count3, 1);
        reset3 = 1'b1; tick(); reset3 = 1'b0;
        chk("p3.rst.active", active_player3, 0);
        chk("p3.rst.maker", maker_id3, 0);
        chk("p3.rst.breaker", breaker_id3, 0);
        chk("p3.rst.cb", code_breaker3, 0);
        chk("p3.rst.cm", code_maker3, 0);
        chk("p3.rst.gc", guess_count3, 0);
        chk("p3.rst.round", round3, 0);
        chk("p3.rst.pts", round_points3, 0);
        chk("p3.rst.over", game_over3, 0);
        chk("p3.rst.rdone", round_done3, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
